// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-port bus arbiter.
// The optional watchdog is selected with the BUS_ARBITER_TIMEOUT_EN macro.
package bus_arbiter_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} ArbState_t;
  typedef logic ArbPort_t;

  localparam int       ARB_DEFAULT_TIMEOUT = 255;
  localparam int       ARB_ADDR_W          = 32;
  localparam int       ARB_DATA_W          = 32;
  localparam int       ARB_MASK_W          = 4;
  localparam int       ARB_WD_CNT_W        = 10;
  localparam ArbPort_t ARB_M0              = 1'b0;
  localparam ArbPort_t ARB_M1              = 1'b1;
endpackage

// File: rtl/bus_if.sv
// Simple request/stall bus: a transfer completes on the first cycle with read|write=1 and stall=0.
// master drives the request side, slave drives stall and read data.
interface Bus_if;
  import bus_arbiter_pkg::*;

  logic [ARB_ADDR_W-1:0] address;
  logic                  read;
  logic                  write;
  logic [ARB_DATA_W-1:0] data_wr;
  logic [ARB_MASK_W-1:0] mask;
  logic                  stall;
  logic [ARB_DATA_W-1:0] data_rd;
  logic [ARB_DATA_W-1:0] data_rd_2;

  modport master (output address, read, write, data_wr, mask,
                  input  stall, data_rd, data_rd_2);
  modport slave  (input  address, read, write, data_wr, mask,
                  output stall, data_rd, data_rd_2);
endinterface

// File: rtl/arb_watchdog.sv
// Stall watchdog for bus_arbiter; only present when BUS_ARBITER_TIMEOUT_EN is defined.
// Counts stalled BUSY cycles and aborts the owner's transfer at TIMEOUT_CYCLES.
`ifdef BUS_ARBITER_TIMEOUT_EN
module arb_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic armed,
  input  logic stall,
  output logic abort,
  output logic timeout_err,
  output logic timeout_sticky
);
  logic [ARB_WD_CNT_W-1:0] wd_cnt;
  logic                    sticky_q;

  assign abort          = armed && (wd_cnt == ARB_WD_CNT_W'(TIMEOUT_CYCLES));
  assign timeout_err    = abort;
  assign timeout_sticky = rst_n & sticky_q;

  // start loads 1 because the stalled IDLE cycle already counts as the first wait
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt   <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (abort) sticky_q <= 1'b1;
      if (start)                        wd_cnt <= ARB_WD_CNT_W'(1);
      else if (armed && stall && !abort) wd_cnt <= wd_cnt + 1'b1;
      else                              wd_cnt <= '0;
    end
  end
endmodule
`endif

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter onto one shared bus, zero added latency in IDLE.
// Define BUS_ARBITER_TIMEOUT_EN to compile in the stall watchdog (arb_watchdog).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
  input  logic      clk,
  input  logic      rst_n,
  Bus_if.slave      m0,
  Bus_if.slave      m1,
  Bus_if.master     s,
  output logic      timeout_err,
  output logic      timeout_sticky,
  output ArbState_t dbg_state
);
  ArbState_t state;
  ArbPort_t  owner, last, winner, sel;
  logic      req0, req1, any_req, owner_req, abort, fwd, granted;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..1023");
  end

  assign req0      = m0.read | m0.write;
  assign req1      = m1.read | m1.write;
  assign any_req   = req0 | req1;
  assign owner_req = (owner == ARB_M1) ? req1 : req0;
  assign dbg_state = state;

  always_comb begin
    winner = ARB_M0;
    if (req0 && req1) winner = ~last;
    else if (req1)    winner = ARB_M1;
  end

  // BUSY keeps the owner on the bus even if it drops its request; only read/write are masked
  assign sel     = (state == ARB_BUSY) ? owner : winner;
  assign fwd     = rst_n && ((state == ARB_BUSY) || any_req);
  assign granted = fwd && ((state == ARB_IDLE) || (owner_req && !abort));

`ifdef BUS_ARBITER_TIMEOUT_EN
  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (rst_n && (state == ARB_IDLE) && any_req && s.stall),
    .armed          (rst_n && (state == ARB_BUSY) && owner_req),
    .stall          (s.stall),
    .abort          (abort),
    .timeout_err    (timeout_err),
    .timeout_sticky (timeout_sticky)
  );
`else
  assign abort          = 1'b0;
  assign timeout_err    = 1'b0;
  assign timeout_sticky = 1'b0;
`endif

  // Default stall equals the port's own request: requesting-but-not-granted waits, idle ports see 0
  always_comb begin
    s.address    = '0;
    s.read       = 1'b0;
    s.write      = 1'b0;
    s.data_wr    = '0;
    s.mask       = '0;
    m0.stall     = req0;
    m0.data_rd   = '0;
    m0.data_rd_2 = '0;
    m1.stall     = req1;
    m1.data_rd   = '0;
    m1.data_rd_2 = '0;
    if (fwd) begin
      if (sel == ARB_M1) begin
        s.address = m1.address;
        s.read    = m1.read;
        s.write   = m1.write;
        s.data_wr = m1.data_wr;
        s.mask    = m1.mask;
      end else begin
        s.address = m0.address;
        s.read    = m0.read;
        s.write   = m0.write;
        s.data_wr = m0.data_wr;
        s.mask    = m0.mask;
      end
      if ((state == ARB_BUSY) && (!owner_req || abort)) begin
        s.read  = 1'b0;
        s.write = 1'b0;
      end
    end
    if (granted) begin
      if (sel == ARB_M1) begin
        m1.stall     = s.stall;
        m1.data_rd   = s.data_rd;
        m1.data_rd_2 = s.data_rd_2;
      end else begin
        m0.stall     = s.stall;
        m0.data_rd   = s.data_rd;
        m0.data_rd_2 = s.data_rd_2;
      end
    end
    if (abort) begin
      if (owner == ARB_M1) m1.stall = 1'b0;
      else                 m0.stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= ARB_M0;
      last  <= ARB_M1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            if (s.stall) begin
              state <= ARB_BUSY;
              owner <= winner;
            end else begin
              last <= winner;
            end
          end
        end
        ARB_BUSY: begin
          if (!owner_req || abort || !s.stall) begin
            state <= ARB_IDLE;
            last  <= owner;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios then constrained-random traffic against a port-indexed model.
// Build with or without BUS_ARBITER_TIMEOUT_EN; the model follows the same macro.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int TO = 4;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  Bus_if m0_bus ();
  Bus_if m1_bus ();
  Bus_if s_bus ();
  logic      timeout_err, timeout_sticky;
  ArbState_t dbg_state;

  // Requester stimulus held per port index
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [3:0]  msk  [2];
  logic        stl;
  logic [31:0] rdat, rdat2;

  assign m0_bus.read    = rd[0];
  assign m0_bus.write   = wr[0];
  assign m0_bus.address = addr[0];
  assign m0_bus.data_wr = wdat[0];
  assign m0_bus.mask    = msk[0];
  assign m1_bus.read    = rd[1];
  assign m1_bus.write   = wr[1];
  assign m1_bus.address = addr[1];
  assign m1_bus.data_wr = wdat[1];
  assign m1_bus.mask    = msk[1];
  assign s_bus.stall     = stl;
  assign s_bus.data_rd   = rdat;
  assign s_bus.data_rd_2 = rdat2;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .s              (s_bus),
    .timeout_err    (timeout_err),
    .timeout_sticky (timeout_sticky),
    .dbg_state      (dbg_state)
  );

  // ---------------- reference model state ----------------
  bit mdl_busy;
  int mdl_owner, mdl_last, mdl_cnt;
  bit mdl_sticky;
  int fin_port;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Snapshot of DUT outputs from the most recent step
  logic [31:0] cap_saddr, cap_swd, cap_drd0;
  logic        cap_sread, cap_swrite, cap_err, cap_sticky, cap_state;
  logic [3:0]  cap_smask;
  logic        cap_stall [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver / checker step ----------------
  task automatic step(input string tag);
    logic [31:0] e_saddr, e_swd;
    logic        e_srd, e_swr;
    logic [3:0]  e_smask;
    logic        e_stl  [2];
    logic [31:0] e_drd  [2];
    logic [31:0] e_drd2 [2];
    logic        e_err, abort, owner_req, completes;
    bit          req [2];
    int          w, od;
    logic [32:0] exp_v;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      req[p]    = rd[p] | wr[p];
      e_stl[p]  = req[p];
      e_drd[p]  = '0;
      e_drd2[p] = '0;
    end
    e_saddr = '0; e_swd = '0; e_srd = 1'b0; e_swr = 1'b0; e_smask = '0;
    e_err = 1'b0; abort = 1'b0; owner_req = 1'b0; completes = 1'b0;
    w = -1;
    fin_port = -1;
    if (rst_n) begin
      if (mdl_busy) begin
        w         = mdl_owner;
        owner_req = req[w];
        abort     = WD_EN && owner_req && (mdl_cnt == TO);
        completes = owner_req && !abort && !stl;
      end else if (req[0] || req[1]) begin
        w         = (req[0] && req[1]) ? 1 - mdl_last : (req[1] ? 1 : 0);
        owner_req = 1'b1;
        completes = !stl;
      end
      if (w >= 0) begin
        e_saddr = addr[w]; e_swd = wdat[w]; e_smask = msk[w];
        e_srd   = rd[w] && owner_req && !abort;
        e_swr   = wr[w] && owner_req && !abort;
        if (abort) e_stl[w] = 1'b0;
        else if (owner_req) begin
          e_stl[w]  = stl;
          e_drd[w]  = rdat;
          e_drd2[w] = rdat2;
        end
      end
      e_err = abort;
    end
    if (completes) exp_q.push_back({1'(w), addr[w]});
    if (completes || abort) fin_port = w;

    chk({tag, "/s_addr"},  s_bus.address, e_saddr);
    chk({tag, "/s_read"},  32'(s_bus.read), 32'(e_srd));
    chk({tag, "/s_write"}, 32'(s_bus.write), 32'(e_swr));
    chk({tag, "/s_wdata"}, s_bus.data_wr, e_swd);
    chk({tag, "/s_mask"},  32'(s_bus.mask), 32'(e_smask));
    chk({tag, "/m0_stall"}, 32'(m0_bus.stall), 32'(e_stl[0]));
    chk({tag, "/m0_rd"},    m0_bus.data_rd, e_drd[0]);
    chk({tag, "/m0_rd2"},   m0_bus.data_rd_2, e_drd2[0]);
    chk({tag, "/m1_stall"}, 32'(m1_bus.stall), 32'(e_stl[1]));
    chk({tag, "/m1_rd"},    m1_bus.data_rd, e_drd[1]);
    chk({tag, "/m1_rd2"},   m1_bus.data_rd_2, e_drd2[1]);
    chk({tag, "/t_err"},    32'(timeout_err), 32'(e_err));
    chk({tag, "/t_sticky"}, 32'(timeout_sticky), 32'(rst_n && mdl_sticky));
    chk({tag, "/state"},    32'(dbg_state), 32'(mdl_busy));

    // Observed completion: a requesting port released without an abort
    od = -1;
    if (rst_n && !timeout_err) begin
      if (req[0] && !m0_bus.stall) od = 0;
      else if (req[1] && !m1_bus.stall) od = 1;
    end
    if (od >= 0) begin
      chk({tag, "/sb_avail"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        chk({tag, "/sb_port"}, 32'(od), 32'(exp_v[32]));
        chk({tag, "/sb_addr"}, s_bus.address, exp_v[31:0]);
      end
    end
    chk({tag, "/sb_left"}, 32'(exp_q.size()), 32'd0);

    cap_saddr = s_bus.address; cap_swd = s_bus.data_wr; cap_smask = s_bus.mask;
    cap_sread = s_bus.read; cap_swrite = s_bus.write;
    cap_stall[0] = m0_bus.stall; cap_stall[1] = m1_bus.stall;
    cap_drd0 = m0_bus.data_rd;
    cap_err = timeout_err; cap_sticky = timeout_sticky; cap_state = dbg_state;

    // Advance the model across the coming edge
    if (!rst_n) begin
      mdl_busy = 1'b0; mdl_owner = 0; mdl_last = 1; mdl_cnt = 0; mdl_sticky = 1'b0;
    end else if (mdl_busy) begin
      if (abort) mdl_sticky = 1'b1;
      if (!owner_req || abort || !stl) begin
        mdl_busy = 1'b0; mdl_last = w; mdl_cnt = 0;
      end else begin
        mdl_cnt++;
      end
    end else if (w >= 0) begin
      if (stl) begin
        mdl_busy = 1'b1; mdl_owner = w; mdl_cnt = 1;
      end else begin
        mdl_last = w;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    for (int p = 0; p < 2; p++) begin
      rd[p] = 1'b0; wr[p] = 1'b0;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int unsigned kind;
    for (int p = 0; p < 2; p++) begin
      rd[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; wdat[p] = '0; msk[p] = '0;
    end
    stl = 1'b0; rdat = '0; rdat2 = '0; rst_n = 1'b0;
    mdl_busy = 1'b0; mdl_owner = 0; mdl_last = 1; mdl_cnt = 0; mdl_sticky = 1'b0;

    step("rst0");
    rd[0] = 1'b1; addr[0] = 32'h0000_0abc; stl = 1'b0;
    step("rst1");
    chk("rst_m0_stall_eq_req", 32'(cap_stall[0]), 32'd1);
    chk("rst_s_read", 32'(cap_sread), 32'd0);
    chk("rst_s_addr", cap_saddr, 32'd0);
    rd[0] = 1'b0;
    rst_n = 1'b1;

    // simultaneous reads after reset: m0 first, m1 next cycle
    rd[0] = 1'b1; addr[0] = 32'h0000_0100;
    rd[1] = 1'b1; addr[1] = 32'h1FC0_0000;
    rdat = 32'h1111_2222; rdat2 = 32'h3333_4444;
    step("tie_a");
    chk("tie_a_addr", cap_saddr, 32'h0000_0100);
    chk("tie_a_m1_stall", 32'(cap_stall[1]), 32'd1);
    chk("tie_a_m0_data", cap_drd0, 32'h1111_2222);
    rd[0] = 1'b0;
    step("tie_b");
    chk("tie_b_addr", cap_saddr, 32'h1FC0_0000);
    chk("tie_b_m1_stall", 32'(cap_stall[1]), 32'd0);
    rd[1] = 1'b0;

    // continuous contention alternates m0,m1,...
    rd[0] = 1'b1; addr[0] = 32'h0000_1000;
    rd[1] = 1'b1; addr[1] = 32'h0000_2000;
    for (int i = 0; i < 8; i++) begin
      step("rr");
      chk("rr_grant_addr", cap_saddr, (i % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000);
    end
    idle_ports();

    // m1 write stalled 3 cycles, m0 arrives in cycle 2
    wr[1] = 1'b1; addr[1] = 32'h0000_0040; wdat[1] = 32'hA5A5_5A5A; msk[1] = 4'b0011;
    addr[0] = 32'h0000_0200;
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) rd[0] = 1'b1;
      stl = (i < 4);
      step("hold");
      chk("hold_addr", cap_saddr, 32'h0000_0040);
      chk("hold_wdata", cap_swd, 32'hA5A5_5A5A);
      chk("hold_mask", 32'(cap_smask), 32'h3);
      chk("hold_write", 32'(cap_swrite), 32'd1);
      if (i >= 2) chk("hold_m0_stall", 32'(cap_stall[0]), 32'd1);
    end
    wr[1] = 1'b0;
    step("hold_c5");
    chk("hold_c5_addr", cap_saddr, 32'h0000_0200);
    chk("hold_c5_m0_stall", 32'(cap_stall[0]), 32'd0);
    rd[0] = 1'b0;

    // stall held: watchdog aborts in 4th BUSY cycle when compiled in
    rd[0] = 1'b1; addr[0] = 32'h0000_0300; stl = 1'b1; rdat = 32'hDEAD_BEEF;
    for (int i = 0; i <= 4; i++) begin
      step("wd");
      chk("wd_err", 32'(cap_err), 32'(WD_EN && i == 4));
      chk("wd_state", 32'(cap_state), 32'(i >= 1));
      if (i == 4) begin
        chk("wd_owner_stall", 32'(cap_stall[0]), WD_EN ? 32'd0 : 32'd1);
        chk("wd_owner_data", cap_drd0, WD_EN ? 32'd0 : 32'hDEAD_BEEF);
        chk("wd_s_read", 32'(cap_sread), WD_EN ? 32'd0 : 32'd1);
      end
    end
    rd[0] = 1'b0; stl = 1'b0;
    step("wd_after");
    chk("wd_sticky", 32'(cap_sticky), 32'(WD_EN));
    chk("wd_err_once", 32'(cap_err), 32'd0);

    // reset in the middle of an m0 BUSY transfer
    rd[0] = 1'b1; addr[0] = 32'h0000_0400; stl = 1'b1;
    step("rb_go");
    step("rb_busy");
    chk("rb_busy_state", 32'(cap_state), 32'd1);
    rst_n = 1'b0;
    step("rb_rst");
    chk("rb_rst_s_read", 32'(cap_sread), 32'd0);
    chk("rb_rst_m0_stall", 32'(cap_stall[0]), 32'd1);
    rst_n = 1'b1; stl = 1'b0;
    rd[1] = 1'b1; addr[1] = 32'h0000_0500;
    step("rb_rel");
    chk("rb_rel_state", 32'(cap_state), 32'd0);
    chk("rb_rel_addr", cap_saddr, 32'h0000_0400);
    chk("rb_rel_sticky", 32'(cap_sticky), 32'd0);
    idle_ports();

    // constrained-random traffic; requests held until served or aborted
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rd[p] && !wr[p]) begin
          addr[p] = $urandom; wdat[p] = $urandom; msk[p] = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 2) == 0) begin
            kind  = $urandom_range(1, 3);
            rd[p] = kind[0];
            wr[p] = kind[1];
          end
        end
      end
      stl   = ($urandom_range(0, 9) < 5);
      rdat  = $urandom;
      rdat2 = $urandom;
      rst_n = ($urandom_range(0, 99) != 0);
      step("rand");
      if (fin_port >= 0) begin
        rd[fin_port] = 1'b0;
        wr[fin_port] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: downstream stall cycles tolerated before abort (1..1023).
REQ-003 Port clk, input, 1: base clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous active-low reset.
REQ-005 Port m0, Bus_if.slave, 32-bit address/data, 4-bit mask: data-side requester (tie winner after reset).
REQ-006 Port m1, Bus_if.slave, 32-bit address/data, 4-bit mask: instruction-fetch requester.
REQ-007 Port s, Bus_if.master, 32-bit address/data, 4-bit mask: shared downstream bus.
REQ-008 Port timeout_err, output, 1: one-cycle pulse on watchdog abort.
REQ-009 Port timeout_sticky, output, 1: set on abort; cleared only by reset.

Function
REQ-010 Request definition: port requests when read|write=1; a request completes on the first cycle it is forwarded with s.stall=0.
REQ-011 States: IDLE and BUSY; registers owner and last (1 bit each) and wd_cnt (10 bit).
REQ-012 IDLE, single requester: that requester wins the arbitration.
REQ-013 IDLE, both requesting: winner is the port not equal to last (round-robin).
REQ-014 IDLE: winner's address/read/write/data_wr/mask forwarded to s combinationally in the same cycle (zero added latency).
REQ-015 IDLE, s.stall=0: transaction completes; stay IDLE; last<=winner.
REQ-016 IDLE, s.stall=1: go to BUSY; owner<=winner; wd_cnt<=1.
REQ-017 BUSY: forward owner's signals only, regardless of the other port's requests.
REQ-018 BUSY, s.stall=0: go to IDLE; last<=owner; wd_cnt<=0.
REQ-019 BUSY, owner drops read and write (protocol violation): s.read=s.write=0; go to IDLE; last<=owner.
REQ-020 Granted port: stall=s.stall, data_rd=s.data_rd, data_rd_2=s.data_rd_2.
REQ-021 Non-granted requesting port: stall=1, data_rd=data_rd_2=0.
REQ-022 Non-requesting port: stall=0, data_rd=data_rd_2=0.
REQ-023 No requests: s.read=s.write=0; s.address, s.data_wr and s.mask driven to 0.
REQ-024 Simultaneous read and write on one port are forwarded unchanged; no arbitration meaning.

Reset
REQ-025 While rst_n=0: state=IDLE, last=1 (so m0 wins the first tie), owner=0, wd_cnt=0, timeout_sticky=0, timeout_err=0.
REQ-026 While rst_n=0: s.read=s.write=0, s.address/data_wr/mask=0; each port stall equals its own request; data_rd=0.
REQ-027 Reset asserted mid-BUSY abandons the transaction; no completion is reported to the owner.

Configuration
REQ-028 Macro BUS_ARBITER_TIMEOUT_EN: when defined, the watchdog is compiled in.
REQ-029 With the watchdog: in BUSY with s.stall=1, wd_cnt increments each cycle.
REQ-030 With the watchdog: when wd_cnt=TIMEOUT_CYCLES, in that cycle s.read=s.write=0, owner sees stall=0 and data_rd=0, timeout_err=1; next state is IDLE, last<=owner, timeout_sticky<=1.
REQ-031 Without the macro: no counter exists, timeout_err and timeout_sticky are tied 0, and BUSY waits indefinitely.

Structure
REQ-032 Shared package in the common header: ArbState_t enum {ARB_IDLE, ARB_BUSY}, ArbPort_t (1 bit), constant ARB_DEFAULT_TIMEOUT=255.
REQ-033 Sub-module arb_watchdog (counter, compare, err pulse/sticky) SHALL exist only under BUS_ARBITER_TIMEOUT_EN; request muxing stays in bus_arbiter.

Verification
REQ-034 After reset, m0 read 0x0000_0100 and m1 read 0x1FC0_0000 in the same cycle, s.stall=0 -> m0 served that cycle; m1 served the next cycle; m1 stall=1 for exactly 1 cycle.
REQ-035 m1 write 0x0000_0040 data 0xA5A5_5A5A mask 4'b0011, s.stall=1 for 3 cycles; m0 requests in cycle 2 -> s holds m1 values for 4 cycles; m0 stall=1 throughout; m0 granted in cycle 5.
REQ-036 Continuous requests from both ports with s.stall=0 -> grants alternate m0,m1,m0,m1 for 8 cycles.
REQ-037 Macro defined, TIMEOUT_CYCLES=4, s.stall held 1 -> abort in 4th BUSY cycle; timeout_err pulses once; timeout_sticky=1; owner stall=0, data_rd=0.
REQ-038 rst_n=0 during m0 BUSY -> next cycle s.read=s.write=0 and state IDLE; after release with both requesting, m0 wins.
